// File: rtl/rr_slave_arbiter.sv
// Round-robin arbiter that serialises N_MASTERS word-write requests onto one slave req/ack handshake.
// Optional macro ARB_TIMEOUT_EN adds an ack timeout with a timeout_err pulse output.
//
//   state   | meaning
//   IDLE    | no transfer; samples m_req and grants the next requester after ptr
//   BUSY    | slv_req held with latched data, waiting for slv_ack
//   RELEASE | slv_req dropped, waiting for slv_ack to return low
module rr_slave_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 16,
  localparam int GID_W    = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_req,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data,
  output logic [N_MASTERS-1:0]          m_done,
  output logic                          slv_req,
  output logic [DATA_W-1:0]             slv_data,
  input  logic                          slv_ack,
  output logic [GID_W-1:0]              grant_id,
  output logic                          busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                state, state_nxt;
  logic [GID_W-1:0]      ptr, ptr_nxt, grant_nxt, winner;
  logic [N_MASTERS-1:0]  upper_mask, req_upper, m_done_nxt;
  logic [DATA_W-1:0]     winner_data, slv_data_nxt;
  logic                  slv_req_nxt, busy_nxt;

  function automatic logic [GID_W-1:0] lowest_set(input logic [N_MASTERS-1:0] v);
    lowest_set = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = GID_W'(i);
    end
  endfunction

  // Requests above the pointer win first; otherwise wrap to the lowest set bit.
  always_comb begin
    upper_mask = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      upper_mask[i] = (GID_W'(i) > ptr);
    end
    req_upper = m_req & upper_mask;
    winner    = (req_upper != '0) ? lowest_set(req_upper) : lowest_set(m_req);
    winner_data = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (winner == GID_W'(i)) winner_data = m_data[i*DATA_W +: DATA_W];
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt, cnt_nxt;
  logic       to_flag, to_flag_nxt, timeout_err_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant_id;
    slv_req_nxt  = slv_req;
    slv_data_nxt = slv_data;
    m_done_nxt   = '0;
`ifdef ARB_TIMEOUT_EN
    cnt_nxt         = cnt;
    to_flag_nxt     = to_flag;
    timeout_err_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (m_req != '0) begin
          state_nxt    = BUSY;
          ptr_nxt      = winner;
          grant_nxt    = winner;
          slv_data_nxt = winner_data;
          slv_req_nxt  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt     = '0;
          to_flag_nxt = 1'b0;
`endif
        end
      end
      BUSY: begin
        if (slv_ack) begin
          state_nxt   = RELEASE;
          slv_req_nxt = 1'b0;
          m_done_nxt  = N_MASTERS'(1) << grant_id;
`ifdef ARB_TIMEOUT_EN
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt       = RELEASE;
          slv_req_nxt     = 1'b0;
          m_done_nxt      = N_MASTERS'(1) << grant_id;
          timeout_err_nxt = 1'b1;
          to_flag_nxt     = 1'b1;
          cnt_nxt         = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
`endif
        end
      end
      RELEASE: begin
        slv_req_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        // After an abort, sit out the full window so a late ack cannot leak into the next transfer.
        if ((!slv_ack && !to_flag) || cnt == CNT_LAST) state_nxt = IDLE;
        else cnt_nxt = cnt + 8'd1;
`else
        if (!slv_ack) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= GID_W'(N_MASTERS - 1);
      grant_id <= '0;
      slv_req  <= 1'b0;
      slv_data <= '0;
      m_done   <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
      slv_req  <= slv_req_nxt;
      slv_data <= slv_data_nxt;
      m_done   <= m_done_nxt;
      busy     <= busy_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      to_flag     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      to_flag     <= to_flag_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_rr_slave_arbiter.sv
// Bench for rr_slave_arbiter: directed cases plus randomized requesters against a transaction-level model.
`timescale 1ns/1ps
module tb_rr_slave_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam int GW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_req = '0;
  logic [N*DW-1:0] m_data = '0;
  logic [N-1:0]    m_done;
  logic            slv_req;
  logic [DW-1:0]   slv_data;
  logic            slv_ack;
  logic [GW-1:0]   grant_id;
  logic            busy;
`ifdef ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  logic            ack_q;
  logic            ack_en = 1'b1;
  logic            spur = 1'b0;
  logic [DW-1:0]   last_data;

  int  tests = 0;
  int  fails = 0;
  bit  model_en = 1'b0;
  int  glog[$];
  int  done_cnt = 0;
  logic prev_req = 1'b0;

  always #5 clk = ~clk;

  rr_slave_arbiter #(.N_MASTERS(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_data(m_data), .m_done(m_done),
    .slv_req(slv_req), .slv_data(slv_data), .slv_ack(slv_ack), .grant_id(grant_id), .busy(busy)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // Standard slave: registers req into ack and captures the data word.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q     <= 1'b0;
      last_data <= '0;
    end else begin
      ack_q <= slv_req;
      if (slv_req) last_data <= slv_data;
    end
  end
  assign slv_ack = (ack_q & ack_en) | spur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: ph counts cycles since the grant (0 = idle); a transfer spans ph 1..4.
  int            ph;
  int            mptr;
  int            mgid;
  logic [DW-1:0] mlat;

  function automatic int pick(input int p, input logic [N-1:0] r);
    logic [N-1:0] sh;
    for (int k = 1; k <= N; k++) begin
      sh = r >> ((p + k) % N);
      if (sh[0]) return (p + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [DW-1:0] data_of(input logic [N*DW-1:0] d, input int w);
    return DW'(d >> (w * DW));
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int w;
    if (!rst_n) begin
      ph   <= 0;
      mptr <= N - 1;
      mgid <= 0;
      mlat <= '0;
    end else if (ph == 0) begin
      if (m_req != '0) begin
        w = pick(mptr, m_req);
        ph   <= 1;
        mptr <= w;
        mgid <= w;
        mlat <= data_of(m_data, w);
      end
    end else begin
      ph <= (ph == 4) ? 0 : ph + 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_done;
    if (model_en && rst_n) begin
      exp_done = (ph == 3) ? (N'(1) << mgid) : '0;
      check("slv_req", 64'(slv_req), 64'(ph == 1 || ph == 2));
      check("busy", 64'(busy), 64'(ph >= 1));
      check("m_done", 64'(m_done), 64'(exp_done));
      check("grant_id", 64'(grant_id), 64'(mgid));
      if (ph == 1 || ph == 2) check("slv_data", 64'(slv_data), 64'(mlat));
      if (ph == 3) check("last_data", 64'(last_data), 64'(mlat));
    end
  end

  task automatic tick();
    @(negedge clk);
    if (slv_req && !prev_req) glog.push_back(int'(grant_id));
    prev_req = slv_req;
    done_cnt += $countones(m_done);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_req = '0;
    spur  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    glog.delete();
    done_cnt = 0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int to_cyc, idle_cyc;
    logic req_at_to;
    logic [N-1:0] done_at_to;

    do_reset();
    model_en = 1'b1;

    // Reset state
    tick();
    check("rst_slv_req", 64'(slv_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_m_done", 64'(m_done), 64'd0);
    check("rst_grant_id", 64'(grant_id), 64'd0);
    check("rst_slv_data", 64'(slv_data), 64'd0);

    // Single requester 2
    m_data[2*DW +: DW] = 32'hDEADBEEF;
    m_req = 4'b0100;
    tick();
    check("single_gid", 64'(grant_id), 64'd2);
    check("single_req", 64'(slv_req), 64'd1);
    check("single_data", 64'(slv_data), 64'hDEADBEEF);
    tick();
    tick();
    check("single_done", 64'(m_done), 64'h4);
    m_req = '0;
    tick();
    check("single_done_off", 64'(m_done), 64'd0);
    check("single_slave", 64'(last_data), 64'hDEADBEEF);
    repeat (3) tick();

    // All four requesting continuously from reset
    do_reset();
    for (int i = 0; i < N; i++) m_data[i*DW +: DW] = $urandom;
    m_req = '1;
    repeat (40) tick();
    m_req = '0;
    check("rr_count", 64'(glog.size()), 64'd8);
    check("rr_dones", 64'(done_cnt), 64'd8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      check($sformatf("rr_order%0d", k), 64'(glog[k]), 64'(k % N));
    repeat (5) tick();

    // Wrap-around from ptr=0 with m_req=1001
    do_reset();
    m_req = 4'b0001;
    repeat (3) tick();
    m_req = 4'b1001;
    repeat (12) tick();
    m_req = '0;
    check("wrap_count", 64'(glog.size()), 64'd3);
    if (glog.size() >= 3) begin
      check("wrap_first", 64'(glog[0]), 64'd0);
      check("wrap_second", 64'(glog[1]), 64'd3);
      check("wrap_third", 64'(glog[2]), 64'd0);
    end
    repeat (5) tick();

    // Granted requester changes data during BUSY
    do_reset();
    m_data[DW +: DW] = 32'hA5A55A5A;
    m_req = 4'b0010;
    tick();
    check("hold_data1", 64'(slv_data), 64'hA5A55A5A);
    m_data[DW +: DW] = 32'h0;
    tick();
    check("hold_data2", 64'(slv_data), 64'hA5A55A5A);
    tick();
    check("hold_done", 64'(m_done), 64'h2);
    check("hold_slave", 64'(last_data), 64'hA5A55A5A);
    m_req = '0;
    repeat (4) tick();

    // Reset mid-transfer
    m_req = 4'b0100;
    tick();
    check("pre_rst_req", 64'(slv_req), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", 64'(slv_req), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(m_done), 64'd0);
    m_req = '1;
    tick();
    tick();
    check("midrst_nodone", 64'(m_done), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_gid", 64'(grant_id), 64'd0);
    check("post_rst_req", 64'(slv_req), 64'd1);
    repeat (2) tick();
    m_req = '0;
    repeat (6) tick();

    // Spurious ack while idle
    spur = 1'b1;
    repeat (3) begin
      tick();
      check("spur_done", 64'(m_done), 64'd0);
      check("spur_busy", 64'(busy), 64'd0);
    end
    spur = 1'b0;
    repeat (2) tick();

    // Randomized requesters
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (m_req[i]) begin
          if (m_done[i] && $urandom_range(1, 0) == 1) m_req[i] = 1'b0;
          else if ($urandom_range(15, 0) == 0) m_req[i] = 1'b0;
        end else if ($urandom_range(3, 0) == 0) begin
          m_req[i] = 1'b1;
          m_data[i*DW +: DW] = $urandom;
        end
        if ($urandom_range(7, 0) == 0) m_data[i*DW +: DW] = $urandom;
      end
    end
    m_req = '0;
    repeat (6) tick();

`ifdef ARB_TIMEOUT_EN
    // Slave never acks
    model_en = 1'b0;
    do_reset();
    ack_en = 1'b0;
    to_cyc = -1;
    idle_cyc = -1;
    req_at_to = 1'b1;
    done_at_to = '0;
    m_req = 4'b0001;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (to_cyc >= 0 && c == to_cyc + 1) check("to_pulse_width", 64'(timeout_err), 64'd0);
      if (timeout_err && to_cyc < 0) begin
        to_cyc = c;
        req_at_to = slv_req;
        done_at_to = m_done;
        m_req = '0;
      end
      if (to_cyc >= 0 && !busy && idle_cyc < 0) idle_cyc = c;
    end
    check("to_cycle", 64'(to_cyc), 64'(TO + 1));
    check("to_done", 64'(done_at_to), 64'h1);
    check("to_slv_req", 64'(req_at_to), 64'd0);
    check("to_release_len", 64'(idle_cyc - to_cyc), 64'(TO));
    ack_en = 1'b1;
`else
    to_cyc = 0;
    idle_cyc = 0;
    req_at_to = 1'b0;
    done_at_to = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
